// File: rtl/alu_pipe.sv
// alu_pipe: handshaked execute-stage ALU with registered results, iterative restoring divider; define ALU_PIPE_SRL_EN to enable opcode 11 SRL
module alu_pipe #(
  parameter int DATA_W = 32,
  parameter int RD_W = 7,
  parameter int OPC_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPC_W-1:0]  op,
  input  logic [RD_W-1:0]   rd,
  input  logic [DATA_W-1:0] rs,
  input  logic [DATA_W-1:0] rsi,
  input  logic [DATA_W-1:0] rt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] res,
  output logic [RD_W-1:0]   rd_out,
  output logic [RD_W-1:0]   br_target,
  output logic [OPC_W-1:0]  op_out,
  output logic              div_zero,
  output logic              illegal
);
  localparam int SW = $clog2(DATA_W);
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [DATA_W-1:0] W_V = DATA_W;
  localparam logic [OPC_W-1:0] OP_NOP = 0, OP_LV = 1, OP_MLT = 2, OP_DIV = 3, OP_REST = 4, OP_SUM = 5,
                               OP_CP = 6, OP_B = 7, OP_BEG = 8, OP_SLR = 9, OP_GP = 10, OP_SRL = 11;
  typedef enum logic [1:0] {S_IDLE, S_DIV, S_HOLD} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] quo, dvs, a_res;
  logic [DATA_W:0] rem, shifted, diff;
  logic [RD_W-1:0] d_rd, a_rd, a_br;
  logic d_zero, a_ill, ge, accept, drain_ok, write;
  assign accept = in_valid && in_ready;
  assign drain_ok = !out_valid || out_ready;
  assign write = (accept && op != OP_DIV) || (state == S_DIV && cnt == '0 && drain_ok) || (state == S_HOLD && drain_ok);
  assign shifted = {rem[DATA_W-1:0], quo[DATA_W-1]};
  assign diff = shifted - {1'b0, dvs};
  assign ge = !diff[DATA_W];
  // state register
  always_ff @(posedge clk)
    if (rst) state <= S_IDLE;
    else state <= state_n;
  // next-state logic; a finished quotient waits in HOLD only while an older result is stuck
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: state_n = (accept && op == OP_DIV) ? S_DIV : S_IDLE;
      S_DIV: state_n = (cnt != '0) ? S_DIV : (drain_ok ? S_IDLE : S_HOLD);
      S_HOLD: state_n = drain_ok ? S_IDLE : S_HOLD;
      default: state_n = S_IDLE;
    endcase
  end
  // FSM output: accept only when idle and the output slot is free or freeing
  always_comb in_ready = (state == S_IDLE) && drain_ok;
  // single-cycle ALU result for every non-DIV opcode
  always_comb begin
    a_res = '0;
    a_rd = '0;
    a_br = '0;
    a_ill = 1'b0;
    case (op)
      OP_NOP, OP_DIV: ;
      OP_LV, OP_CP: begin a_res = rsi; a_rd = rd; end
      OP_MLT: begin a_res = rs * rt; a_rd = rd; end
      OP_REST: begin a_res = rs - rt; a_rd = rd; end
      OP_SUM: begin a_res = rs + rt; a_rd = rd; end
      OP_B: a_br = rd;
      OP_BEG: begin a_res = DATA_W'(DATA_W'(rd) > rs); a_br = rt[RD_W-1:0]; end
      OP_SLR: begin a_res = (rt >= W_V) ? '0 : rs << rt[SW-1:0]; a_rd = rd; end
      OP_GP: begin a_res = rs; a_rd = rd; end
`ifdef ALU_PIPE_SRL_EN
      OP_SRL: begin a_res = (rt >= W_V) ? '0 : rs >> rt[SW-1:0]; a_rd = rd; end
`endif
      default: a_ill = 1'b1;
    endcase
  end
  // divide counter: loaded on accept, one step per DIV cycle, 0 marks the write cycle
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (accept && op == OP_DIV) cnt <= CW'(DATA_W);
    else if (state == S_DIV && cnt != '0) cnt <= cnt - 1'b1;
  // restoring divider; a zero divisor naturally yields an all-ones quotient
  always_ff @(posedge clk)
    if (accept && op == OP_DIV) begin
      quo <= rs;
      rem <= '0;
      dvs <= rt;
      d_rd <= rd;
      d_zero <= rt == '0;
    end else if (state == S_DIV && cnt != '0) begin
      quo <= {quo[DATA_W-2:0], ge};
      rem <= ge ? diff : shifted;
    end
  // output register: loads from the ALU on accept or from the divider when done, holds until drained
  always_ff @(posedge clk)
    if (rst) begin
      out_valid <= 1'b0;
      res <= '0;
      rd_out <= '0;
      br_target <= '0;
      op_out <= '0;
      div_zero <= 1'b0;
      illegal <= 1'b0;
    end else if (write) begin
      out_valid <= 1'b1;
      res <= accept ? a_res : quo;
      rd_out <= accept ? a_rd : d_rd;
      br_target <= accept ? a_br : '0;
      op_out <= accept ? op : OP_DIV;
      div_zero <= !accept && d_zero;
      illegal <= accept && a_ill;
    end else if (out_ready) out_valid <= 1'b0;
endmodule
